// File: rtl/ecc_decoder.sv
// Two-stage SECDED decoder for (8,4), (16,11) and (32,26) extended Hamming codes.
// Optional error counters are enabled with `define ECC_DECODER_ERR_CNT_EN.
module ecc_decoder #(
  parameter int unsigned MAX_CODEWORD_WIDTH = 32,
  parameter int unsigned MAX_INFO_WIDTH     = 26
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0] codeword,
  input  logic [1:0]                    mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_INFO_WIDTH-1:0]     data_out,
`ifdef ECC_DECODER_ERR_CNT_EN
  input  logic                          cnt_clr,
  output logic [15:0]                   corr_cnt,
  output logic [15:0]                   uncorr_cnt,
`endif
  output logic [1:0]                    status
);

  localparam int unsigned CW_W  = 32;
  localparam int unsigned SYN_W = 6;

  localparam logic [1:0] MOD_ILL   = 2'b11;
  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_CORR   = 2'b01;
  localparam logic [1:0] ST_UNCORR = 2'b10;
  localparam logic [1:0] ST_ILL    = 2'b11;

  typedef logic [SYN_W-1:0][CW_W-1:0] h_t;

  // Rows above P-1 are zero, so unused syndrome bits and columns beyond N stay zero.
  localparam h_t H_M0 = {32'h0, 32'h0, 32'h000000ff, 32'h000000e4, 32'h000000d2, 32'h000000b1};
  localparam h_t H_M1 = {32'h0, 32'h0000ffff, 32'h0000fe08, 32'h0000f1c4, 32'h0000cda2,
                         32'h0000ab61};
  localparam h_t H_M2 = {32'hffffffff, 32'hfffe0010, 32'hff01fc08, 32'hf0f1e384, 32'hcccd9b42,
                         32'haaab56c1};

  typedef struct packed {
    logic [CW_W-1:0]  cw;
    logic [1:0]       mod;
    logic [SYN_W-1:0] syn;
  } s1_t;

  function automatic h_t h_of(input logic [1:0] m);
    case (m)
      2'b00:   return H_M0;
      2'b01:   return H_M1;
      2'b10:   return H_M2;
      default: return '0;
    endcase
  endfunction

  function automatic logic [CW_W-1:0] n_mask(input logic [1:0] m);
    case (m)
      2'b00:   return 32'h000000ff;
      2'b01:   return 32'h0000ffff;
      2'b10:   return 32'hffffffff;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [2:0] p_of(input logic [1:0] m);
    case (m)
      2'b00:   return 3'd4;
      2'b01:   return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  logic             adv;
  logic             s1_valid;
  s1_t              s1;
  logic [CW_W-1:0]  cw_in;
  h_t               h_in;
  logic [SYN_W-1:0] syn_in;

  h_t                      h2;
  logic [2:0]              p2;
  logic                    top;
  logic                    hit;
  logic [SYN_W-1:0]        col;
  logic [CW_W-1:0]         flip;
  logic [CW_W-1:0]         fixed;
  logic [1:0]              st_nx;
  logic [MAX_INFO_WIDTH-1:0] info_nx;

  assign adv      = !out_valid || out_ready;
  assign in_ready = rst && adv;

  // Stage 1 input side: mask to N and compute the syndrome.
  always_comb begin
    cw_in  = CW_W'(codeword) & n_mask(mod);
    h_in   = h_of(mod);
    syn_in = '0;
    for (int r = 0; r < SYN_W; r++) begin
      syn_in[r] = ^(h_in[r] & cw_in);
    end
  end

  // Stage 2 input side: first matching H column names the bit to flip.
  always_comb begin
    h2    = h_of(s1.mod);
    p2    = p_of(s1.mod);
    top   = s1.syn[p2 - 3'd1];
    hit   = 1'b0;
    col   = '0;
    flip  = '0;
    fixed = s1.cw;
    st_nx = ST_CLEAN;
    for (int j = 0; j < CW_W; j++) begin
      for (int r = 0; r < SYN_W; r++) begin
        col[r] = h2[r][j];
      end
      if (!hit && (col == s1.syn)) begin
        hit     = 1'b1;
        flip[j] = 1'b1;
      end
    end
    if (s1.mod == MOD_ILL) begin
      st_nx = ST_ILL;
    end else if (s1.syn == '0) begin
      st_nx = ST_CLEAN;
    end else if (top && hit) begin
      st_nx = ST_CORR;
      fixed = s1.cw ^ flip;
    end else begin
      st_nx = ST_UNCORR;
    end
    info_nx = (s1.mod == MOD_ILL) ? '0 : MAX_INFO_WIDTH'(fixed >> p2);
  end

  // Both stages move together on adv; a missing input becomes a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1        <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      status    <= ST_CLEAN;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1.cw  <= cw_in;
        s1.mod <= mod;
        s1.syn <= syn_in;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= info_nx;
        status   <= st_nx;
      end
    end
  end

`ifdef ECC_DECODER_ERR_CNT_EN
  // Saturating error counters advance on each consumed result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if ((status == ST_CORR) && (corr_cnt != 16'hffff)) begin
        corr_cnt <= corr_cnt + 16'd1;
      end
      if ((status == ST_UNCORR) && (uncorr_cnt != 16'hffff)) begin
        uncorr_cnt <= uncorr_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ecc_decoder.sv
// Scoreboard bench for ecc_decoder; reference model decodes by nearest-codeword search.
module tb_ecc_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] codeword;
  logic [1:0]  mod;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] data_out;
  logic [1:0]  status;
`ifdef ECC_DECODER_ERR_CNT_EN
  logic        cnt_clr;
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int ready_mode = 0;
  logic [27:0] exp_q[$];

  ecc_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .codeword  (codeword),
    .mod       (mod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
`ifdef ECC_DECODER_ERR_CNT_EN
    .cnt_clr   (cnt_clr),
    .corr_cnt  (corr_cnt),
    .uncorr_cnt(uncorr_cnt),
`endif
    .status    (status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h, required %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int p_of(input int m);
    return (m == 0) ? 4 : (m == 1) ? 5 : 6;
  endfunction

  function automatic int n_of(input int m);
    return (m == 0) ? 8 : (m == 1) ? 16 : 32;
  endfunction

  function automatic logic [31:0] mask_of(input int m);
    return (m == 0) ? 32'h000000ff : (m == 1) ? 32'h0000ffff : 32'hffffffff;
  endfunction

  function automatic logic [31:0] h_row(input int m, input int r);
    logic [31:0] v;
    v = 32'h0;
    case (m)
      0: case (r) 3: v = 32'hff; 2: v = 32'he4; 1: v = 32'hd2; 0: v = 32'hb1; default: v = 32'h0; endcase
      1: case (r) 4: v = 32'hffff; 3: v = 32'hfe08; 2: v = 32'hf1c4; 1: v = 32'hcda2; 0: v = 32'hab61;
                  default: v = 32'h0; endcase
      default: case (r) 5: v = 32'hffffffff; 4: v = 32'hfffe0010; 3: v = 32'hff01fc08;
                        2: v = 32'hf0f1e384; 1: v = 32'hcccd9b42; 0: v = 32'haaab56c1;
                        default: v = 32'h0; endcase
    endcase
    return v;
  endfunction

  // Builds the valid codeword for an info value: Hamming bits, then overall parity.
  function automatic logic [31:0] encode(input int m, input logic [31:0] info);
    int p;
    logic [31:0] cw;
    logic [31:0] par;
    p   = p_of(m);
    cw  = (info << p) & mask_of(m);
    par = 32'h0;
    for (int r = 0; r < p - 1; r++) par[r] = ^(h_row(m, r) & cw);
    cw = cw | par;
    cw[p-1] = ^cw;
    return cw;
  endfunction

  function automatic bit is_codeword(input int m, input logic [31:0] cw);
    return cw == encode(m, cw >> p_of(m));
  endfunction

  function automatic logic [27:0] model(input int m, input logic [31:0] cw_raw);
    logic [31:0] cw;
    logic [31:0] c;
    int p;
    if (m == 3) return {2'b11, 26'h0};
    p  = p_of(m);
    cw = cw_raw & mask_of(m);
    if (is_codeword(m, cw)) return {2'b00, 26'(cw >> p)};
    for (int j = 0; j < n_of(m); j++) begin
      c = cw ^ (32'h1 << j);
      if (is_codeword(m, c)) return {2'b01, 26'(c >> p)};
    end
    return {2'b10, 26'(cw >> p)};
  endfunction

  // ---------------- driver ----------------
  task automatic send(input int m, input logic [31:0] cw, input logic [27:0] e);
    int waited;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    mod      = 2'(m);
    codeword = cw;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (in_ready) begin
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end else begin
      n_total++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [27:0] e;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      #1;
      if (rst && out_valid) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: status %0d data %h emitted, required no output",
                   status, data_out);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          check("beat", 32'({status, data_out}), 32'(e));
        end else begin
          check("stall_hold", 32'({status, data_out}), 32'(exp_q[0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int m;
    int nf;
    int w;
    logic [31:0] info;
    logic [31:0] cw;

    rst      = 1'b0;
    in_valid = 1'b0;
    codeword = 32'h0;
    mod      = 2'b00;
`ifdef ECC_DECODER_ERR_CNT_EN
    cnt_clr  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_status", 32'({status, data_out}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // directed: clean, single, double, illegal
    send(0, 32'h00, {2'b00, 26'h0});
    send(0, 32'h20, {2'b01, 26'h0});
    send(0, 32'h03, {2'b10, 26'h0});
    send(3, 32'h5a5a5a5a, {2'b11, 26'h0});
    drain();

    // two-cycle latency with no stall
    send(1, encode(1, 32'h5a5), {2'b00, 26'h5a5});
    check("latency_c1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("latency_c2", 32'(out_valid), 32'd1);
    drain();

    // every single-bit error position in every mode
    for (int mm = 0; mm < 3; mm++) begin
      for (int j = 0; j < n_of(mm); j++) begin
        info = $urandom() & (mask_of(mm) >> p_of(mm));
        send(mm, encode(mm, info) ^ (32'h1 << j), {2'b01, 26'(info)});
      end
    end
    drain();

    // back-to-back with alternating mode and toggling backpressure
    ready_mode = 1;
    for (int i = 0; i < 8; i++) begin
      m    = i % 3;
      info = $urandom() & (mask_of(m) >> p_of(m));
      cw   = encode(m, info) ^ (32'h1 << $urandom_range(0, n_of(m) - 1));
      send(m, cw, model(m, cw));
    end
    drain();

    // randomized traffic with random gaps and backpressure
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      m = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      if (m == 3) begin
        cw = $urandom();
      end else begin
        info = $urandom() & (mask_of(m) >> p_of(m));
        cw   = encode(m, info);
        nf   = int'($urandom_range(0, 3));
        for (int k = 0; k < nf; k++) cw = cw ^ (32'h1 << $urandom_range(0, n_of(m) - 1));
        if ($urandom_range(0, 7) == 0) cw = cw | (~mask_of(m) & $urandom());
      end
      send(m, cw, model(m, cw));
      if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end
    ready_mode = 0;
    drain();

    // reset with two beats in flight
    ready_mode = 3;
    @(negedge clk);
    send(0, encode(0, 32'ha), {2'b00, 26'ha});
    send(0, encode(0, 32'h5), {2'b00, 26'h5});
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_data_status", 32'({status, data_out}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ready_mode = 0;
    #1;
    check("midrst_rel_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("midrst_no_ghost", 32'(out_valid), 32'd0);
    end

`ifdef ECC_DECODER_ERR_CNT_EN
    check("cnt_rst_corr", 32'(corr_cnt), 32'd0);
    check("cnt_rst_uncorr", 32'(uncorr_cnt), 32'd0);
    for (int i = 0; i < 32'h10000; i++) send(0, 32'h20, {2'b01, 26'h0});
    drain();
    check("cnt_sat_corr", 32'(corr_cnt), 32'hffff);
    check("cnt_uncorr_zero", 32'(uncorr_cnt), 32'd0);
    send(0, 32'h03, {2'b10, 26'h0});
    drain();
    check("cnt_uncorr_one", 32'(uncorr_cnt), 32'd1);
    send(0, 32'h20, {2'b01, 26'h0});
    w = 0;
    do begin
      @(negedge clk);
      #1;
      w++;
    end while (!out_valid && w < 20);
    check("cnt_clr_wait", 32'(out_valid), 32'd1);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check("cnt_clr_corr", 32'(corr_cnt), 32'd0);
    check("cnt_clr_uncorr", 32'(uncorr_cnt), 32'd0);
    drain();
`else
    w = 0;
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
